countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter Size, default 5: width of the count and load value in bits.
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port load_valid  input  1  request to load a start value.
REQ-005 SHALL have port load_ready  output  1  timer can accept a load.
REQ-006 SHALL have port load_value  input  Size  start value N, sampled on handshake.
REQ-007 SHALL have port auto_reload  input  1  periodic mode, sampled on handshake.
REQ-008 SHALL have port enable  input  1  count advance; 0 = pause.
REQ-009 SHALL have port stop  input  1  synchronous abort.
REQ-010 SHALL have port irq_clear  input  1  clears irq.
REQ-011 SHALL have port count  output  Size  current count, registered.
REQ-012 SHALL have port busy  output  1  timer running or paused, registered.
REQ-013 SHALL have port expired  output  1  one-cycle terminal-count pulse, registered.
REQ-014 SHALL have port irq  output  1  sticky expiry flag, registered.

Function
REQ-015 SHALL implement states IDLE and RUN; busy = 1 exactly in RUN.
REQ-016 SHALL drive load_ready = (state == IDLE) and not stop, combinationally.
REQ-017 SHALL accept a load on a rising edge where load_valid and load_ready are both 1; N, auto_reload and the reload register are captured on that edge.
REQ-018 SHALL, on acceptance with N >= 1, set count = N and state = RUN after that edge; first decrement on the next enabled edge.
REQ-019 SHALL, on acceptance with N = 0, hold count = 0, stay IDLE, pulse expired for one cycle after the edge, and ignore auto_reload.
REQ-020 SHALL, in RUN with enable = 1 and count > 1, decrement count by 1 per edge; with enable = 0, hold count and state.
REQ-021 SHALL, in RUN with enable = 1 and count = 1, one-shot: set count = 0, go IDLE, pulse expired.
REQ-022 SHALL, in RUN with enable = 1 and count = 1, auto-reload: set count = reload register, stay RUN, pulse expired.
REQ-023 SHALL give period exactly N enabled cycles from load to first expired, then N between pulses in auto-reload mode.
REQ-024 SHALL treat all arithmetic as unsigned Size-bit; count never wraps below 0; N = 2^Size-1 is legal.
REQ-025 SHALL ignore load_valid while in RUN, with no queuing and no effect on count.
REQ-026 SHALL, on stop = 1, force count = 0 and IDLE on the next edge, with no expired pulse; stop beats load, expiry and enable.
REQ-027 SHALL set irq on every expired pulse and clear it on irq_clear; simultaneous set and clear leaves irq = 1.
REQ-028 SHALL hold expired high for exactly one cycle per terminal count, never two consecutive cycles, except back-to-back in auto-reload with N = 1.

Reset
REQ-029 SHALL, while reset = 0, immediately force count = 0, busy = 0, expired = 0, irq = 0, state IDLE, and reload register 0, regardless of clock.
REQ-030 SHALL abandon any in-progress count on reset; after release, resume operation from IDLE at the first rising edge with reset = 1.

Verification
REQ-031 SHALL cover one-shot: load 5, enable = 1 -> count 5,4,3,2,1,0; expired high only in the cycle count = 0; busy falls same edge; irq = 1.
REQ-032 SHALL cover auto-reload: load 3, auto_reload = 1 -> count 3,2,1,3,2,1,...; expired every 3rd cycle; load_ready stays 0; irq_clear with a pulse -> irq stays 1.
REQ-033 SHALL cover pause: load 4, enable low for 2 cycles after count = 3 -> count holds 3 for two cycles; expired 6 cycles after load.
REQ-034 SHALL cover edge loads: load 0 -> single expired pulse, busy never 1; load 31 -> expired exactly 31 enabled cycles later.
REQ-035 SHALL cover stop and load: stop with load_valid in IDLE -> no acceptance; stop at count = 2 -> count 0, IDLE, no expired.
REQ-036 SHALL cover reset mid-run: load 10, reset low after 3 cycles, mid-cycle -> count 0, busy 0, irq 0, load_ready 1 without waiting for an edge.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot and auto-reload modes.
//
// A start value N is accepted through a valid/ready handshake while idle.
// The timer then counts down once per enabled clock and raises a one-cycle
// `expired` pulse after exactly N enabled cycles. In auto-reload mode it
// restarts from N on every terminal count. `irq` is a sticky copy of the
// expiry pulses.
//
// Ports:
//   clock       in   sole clock, rising edge
//   reset       in   asynchronous active-low reset
//   load_valid  in   request to load a start value
//   load_ready  out  timer can accept a load (idle and not stopping)
//   load_value  in   start value N, sampled on handshake
//   auto_reload in   periodic mode, sampled on handshake
//   enable      in   count advance; 0 pauses
//   stop        in   synchronous abort to idle, no expiry pulse
//   irq_clear   in   clears irq
//   count       out  current count (registered)
//   busy        out  timer running or paused
//   expired     out  one-cycle terminal-count pulse (registered)
//   irq         out  sticky expiry flag (registered)
module countdown_timer #(
  parameter int Size = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [Size-1:0] load_value,
  input  logic            auto_reload,
  input  logic            enable,
  input  logic            stop,
  input  logic            irq_clear,
  output logic [Size-1:0] count,
  output logic            busy,
  output logic            expired,
  output logic            irq
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [Size-1:0] One = Size'(1);

  state_t          state, state_n;
  logic [Size-1:0] count_n;
  logic [Size-1:0] reload, reload_n;
  logic            auto_mode, auto_n;
  logic            expired_n;
  logic            irq_n;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      reload    <= '0;
      auto_mode <= 1'b0;
      expired   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      reload    <= reload_n;
      auto_mode <= auto_n;
      expired   <= expired_n;
      irq       <= irq_n;
    end
  end

  // Next-state logic; stop has priority over load, enable and expiry.
  always_comb begin
    state_n   = state;
    count_n   = count;
    reload_n  = reload;
    auto_n    = auto_mode;
    expired_n = 1'b0;
    if (stop) begin
      state_n = IDLE;
      count_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_valid) begin
            reload_n = load_value;
            auto_n   = auto_reload;
            if (load_value != '0) begin
              count_n = load_value;
              state_n = RUN;
            end else begin
              // Zero-length load expires immediately without running.
              count_n   = '0;
              expired_n = 1'b1;
            end
          end
        end
        RUN: begin
          if (enable) begin
            if (count > One) begin
              count_n = count - One;
            end else begin
              expired_n = 1'b1;
              if (auto_mode) begin
                count_n = reload;
              end else begin
                count_n = '0;
                state_n = IDLE;
              end
            end
          end
        end
        default: begin
          state_n = IDLE;
          count_n = '0;
        end
      endcase
    end
    // Setting wins over a simultaneous clear.
    irq_n = expired_n | (irq & ~irq_clear);
  end

  // Outputs
  always_comb begin
    busy       = (state == RUN);
    load_ready = (state == IDLE) && !stop;
  end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int Size = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic            load_valid;
  logic            load_ready;
  logic [Size-1:0] load_value;
  logic            auto_reload;
  logic            enable;
  logic            stop;
  logic            irq_clear;
  logic [Size-1:0] count;
  logic            busy;
  logic            expired;
  logic            irq;

  int total = 0;
  int bad   = 0;
  bit done  = 0;

  countdown_timer #(.Size(Size)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .auto_reload(auto_reload),
    .enable     (enable),
    .stop       (stop),
    .irq_clear  (irq_clear),
    .count      (count),
    .busy       (busy),
    .expired    (expired),
    .irq        (irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a running timer is described by its period and the
  // number of enabled cycles elapsed since the load.
  bit m_run;
  int m_n;
  bit m_auto;
  int m_ticks;
  bit m_exp;
  bit m_irq;

  function automatic int m_count();
    return m_run ? (m_n - (m_ticks % m_n)) : 0;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_n = 1; m_auto = 0; m_ticks = 0; m_exp = 0; m_irq = 0;
    end else begin
      bit e;
      e = 0;
      if (stop) begin
        m_run = 0;
      end else if (!m_run) begin
        if (load_valid) begin
          if (int'(load_value) == 0) e = 1;
          else begin
            m_run = 1; m_n = int'(load_value); m_auto = auto_reload; m_ticks = 0;
          end
        end
      end else if (enable) begin
        m_ticks++;
        if (m_ticks % m_n == 0) begin
          e = 1;
          if (!m_auto) m_run = 0;
        end
      end
      m_exp = e;
      if (e) m_irq = 1;
      else if (irq_clear) m_irq = 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (!done) begin
      chk("cmp_count", 32'(count), 32'(m_count()));
      chk("cmp_busy", 32'(busy), 32'(m_run));
      chk("cmp_expired", 32'(expired), 32'(m_exp));
      chk("cmp_irq", 32'(irq), 32'(m_irq));
      chk("cmp_load_ready", 32'(load_ready), 32'(!m_run && !stop));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input int n, input bit ar);
    load_valid = 1; load_value = Size'(n); auto_reload = ar;
    tick();
    load_valid = 0; auto_reload = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 0; load_valid = 0; load_value = '0; auto_reload = 0;
    enable = 0; stop = 0; irq_clear = 0;
    repeat (2) tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_ready", 32'(load_ready), 1);
    reset = 1;
    tick();

    // One-shot, N = 5
    enable = 1;
    do_load(5, 0);
    chk("os_load_count", 32'(count), 5);
    chk("os_load_busy", 32'(busy), 1);
    for (int v = 4; v >= 1; v--) begin
      tick();
      chk("os_count", 32'(count), 32'(v));
      chk("os_no_exp", 32'(expired), 0);
    end
    tick();
    chk("os_end_count", 32'(count), 0);
    chk("os_end_exp", 32'(expired), 1);
    chk("os_end_busy", 32'(busy), 0);
    chk("os_end_irq", 32'(irq), 1);
    tick();
    chk("os_exp_once", 32'(expired), 0);
    irq_clear = 1;
    tick();
    irq_clear = 0;
    chk("os_irq_clr", 32'(irq), 0);

    // Auto-reload, N = 3; loads during RUN are ignored.
    do_load(3, 1);
    chk("ar_load_count", 32'(count), 3);
    load_valid = 1; load_value = Size'(7);
    chk("ar_ready_low", 32'(load_ready), 0);
    tick(); chk("ar_c2", 32'(count), 2);
    irq_clear = 1;
    tick(); chk("ar_c1", 32'(count), 1);
    tick();
    chk("ar_reload", 32'(count), 3);
    chk("ar_exp", 32'(expired), 1);
    chk("ar_irq_set_wins", 32'(irq), 1);
    irq_clear = 0;
    tick(); chk("ar_c2b", 32'(count), 2);
    tick(); tick();
    chk("ar_reload2", 32'(count), 3);
    chk("ar_exp2", 32'(expired), 1);
    stop = 1; load_valid = 0;
    tick();
    stop = 0;
    chk("ar_stop_count", 32'(count), 0);
    chk("ar_stop_busy", 32'(busy), 0);

    // Pause, N = 4
    do_load(4, 0);
    tick(); chk("pz_c3", 32'(count), 3);
    enable = 0;
    tick(); chk("pz_hold1", 32'(count), 3);
    tick(); chk("pz_hold2", 32'(count), 3);
    enable = 1;
    tick(); tick();
    chk("pz_c1", 32'(count), 1);
    tick();
    chk("pz_exp", 32'(expired), 1);

    // Load 0: single pulse, never busy
    do_load(0, 1);
    chk("z_exp", 32'(expired), 1);
    chk("z_busy", 32'(busy), 0);
    tick();
    chk("z_exp_gone", 32'(expired), 0);
    chk("z_busy2", 32'(busy), 0);

    // Load 31: expiry after exactly 31 enabled cycles
    do_load(31, 0);
    chk("max_load", 32'(count), 31);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (expired) break;
    end
    chk("max_period", 32'(n), 31);

    // Auto-reload with N = 1: back-to-back pulses
    do_load(1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("n1_exp", 32'(expired), 1);
      chk("n1_count", 32'(count), 1);
    end
    stop = 1;
    tick();
    stop = 0;

    // Stop blocks a load in IDLE
    stop = 1; load_valid = 1; load_value = Size'(6);
    #1 chk("st_ready", 32'(load_ready), 0);
    tick();
    chk("st_noload_busy", 32'(busy), 0);
    chk("st_noload_count", 32'(count), 0);
    stop = 0; load_valid = 0;

    // Stop at count 2
    do_load(5, 0);
    tick(); tick(); tick();
    chk("st_c2", 32'(count), 2);
    stop = 1;
    tick();
    stop = 0;
    chk("st_count", 32'(count), 0);
    chk("st_busy", 32'(busy), 0);
    chk("st_no_exp", 32'(expired), 0);

    // Reset mid-run, mid-cycle
    do_load(10, 0);
    tick(); tick(); tick();
    chk("rr_c7", 32'(count), 7);
    #1 reset = 0;
    #1;
    chk("rr_count", 32'(count), 0);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_irq", 32'(irq), 0);
    chk("rr_ready", 32'(load_ready), 1);
    chk("rr_exp", 32'(expired), 0);
    tick();
    reset = 1;
    tick();
    do_load(2, 0);
    chk("rr_resume", 32'(count), 2);
    tick(); tick();
    chk("rr_resume_exp", 32'(expired), 1);
    tick();

    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
